// File: rtl/pueo_lowamp_envelope_trigger_v3_pkg.sv
// -----------------------------------------------------------------------------
// pueo_lowamp_pkg
// Shared definitions for the low-amplitude envelope trigger:
//   ENVBITS       - width of the saturated envelope and of each threshold
//   THRESH_RESET  - reset value of every threshold (can never be exceeded)
//   holdoff_state_t - per-channel holdoff FSM states
//   boxcar_k()    - boxcar depth in block sums; returns 0 for an illegal BOXLEN
// -----------------------------------------------------------------------------
package pueo_lowamp_pkg;

    localparam int unsigned        ENVBITS      = 18;
    localparam logic [ENVBITS-1:0] THRESH_RESET = 18'h3FFFF;

    typedef enum logic [1:0] {
        HO_IDLE = 2'd0,
        HO_FIRE = 2'd1,
        HO_HOLD = 2'd2
    } holdoff_state_t;

    // BOXLEN must be NSAMP*K with K in {1,2,4,8}; anything else yields 0.
    function automatic int unsigned boxcar_k(input int unsigned boxlen,
                                             input int unsigned nsamp);
        int unsigned k;
        k = 0;
        if ((nsamp != 0) && ((boxlen % nsamp) == 0)) begin
            k = boxlen / nsamp;
            if ((k != 1) && (k != 2) && (k != 4) && (k != 8)) begin
                k = 0;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/pueo_lowamp_envelope_trigger_v3_if.sv
// -----------------------------------------------------------------------------
// pueo_lowamp_envelope_trigger_v3_if
// Threshold programming bus.
//   thresh_dat    - 18-bit threshold write data
//   thresh_addr   - shadow register select, address 2b+t = beam b, threshold t
//   thresh_wr     - write thresh_dat into the addressed shadow register
//   thresh_update - copy every shadow register into its active register
// master: register-bus driver; slave: trigger block.
// -----------------------------------------------------------------------------
interface pueo_lowamp_envelope_trigger_v3_if #(
    parameter int unsigned NBEAMS = 2
) ();
    import pueo_lowamp_pkg::*;

    localparam int unsigned ADDRW = $clog2(2 * NBEAMS);

    logic [ENVBITS-1:0] thresh_dat;
    logic [ADDRW-1:0]   thresh_addr;
    logic               thresh_wr;
    logic               thresh_update;

    modport master (
        output thresh_dat,
        output thresh_addr,
        output thresh_wr,
        output thresh_update
    );

    modport slave (
        input thresh_dat,
        input thresh_addr,
        input thresh_wr,
        input thresh_update
    );

endinterface

// File: rtl/pueo_lowamp_envelope_trigger_v3_holdoff.sv
// -----------------------------------------------------------------------------
// lowamp_trig_holdoff
// One trigger channel: turns a compare result into single-clock pulses
// separated by a programmable holdoff.
//   i_clk, i_rst - clock, asynchronous active-high reset
//   i_hit        - envelope above threshold (already fill-qualified)
//   i_mask       - channel disabled: FSM to IDLE, output gated immediately
//   i_holdoff    - holdoff length in clocks, sampled when HOLD is entered
//   o_trig       - trigger pulse
// -----------------------------------------------------------------------------
module lowamp_trig_holdoff
    import pueo_lowamp_pkg::*;
#(
    parameter int unsigned HOLDBITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_hit,
    input  logic                i_mask,
    input  logic [HOLDBITS-1:0] i_holdoff,
    output logic                o_trig
);

    holdoff_state_t      r_state;
    holdoff_state_t      w_state_nxt;
    logic [HOLDBITS-1:0] r_cnt;
    logic [HOLDBITS-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= HO_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_mask) begin
            w_state_nxt = HO_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                HO_IDLE: begin
                    if (i_hit) begin
                        w_state_nxt = HO_FIRE;
                    end
                end
                HO_FIRE: begin
                    if (i_holdoff == '0) begin
                        w_state_nxt = HO_IDLE;
                    end else begin
                        w_cnt_nxt   = i_holdoff;
                        w_state_nxt = HO_HOLD;
                    end
                end
                HO_HOLD: begin
                    // Hits are dropped here; the count ends on the clock it reads 1.
                    if (r_cnt <= HOLDBITS'(1)) begin
                        w_state_nxt = HO_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - HOLDBITS'(1);
                    end
                end
                default: begin
                    w_state_nxt = HO_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Mask gates the registered pulse combinationally so it drops at once.
    assign o_trig = (r_state == HO_FIRE) && !i_mask;

endmodule

// File: rtl/pueo_lowamp_envelope_trigger_v3.sv
// -----------------------------------------------------------------------------
// pueo_lowamp_envelope_trigger_v3
// Per-beam boxcar envelope of squared samples, compared against two
// double-buffered thresholds per beam, with holdoff-limited trigger pulses.
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   square_i      - squared samples, beam b sample s at [(b*NSAMP+s)*SQBITS +: SQBITS]
//   thr_if        - threshold programming bus (slave)
//   holdoff_i     - holdoff length in clocks, shared by all channels
//   mask_i        - per-beam disable (1 = disabled)
//   envelope_o    - saturated envelope per beam, 18 bits each
//   trigger_o     - trigger pulses, bit 2b+t = beam b, threshold t
// Latency: square_i -> envelope_o 3 clocks, envelope_o -> trigger_o 1 clock.
// -----------------------------------------------------------------------------
module pueo_lowamp_envelope_trigger_v3
    import pueo_lowamp_pkg::*;
#(
    parameter int unsigned NBEAMS   = 2,
    parameter int unsigned NSAMP    = 4,
    parameter int unsigned SQBITS   = 14,
    parameter int unsigned BOXLEN   = 8,
    parameter int unsigned HOLDBITS = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NBEAMS*NSAMP*SQBITS-1:0]   square_i,
    pueo_lowamp_envelope_trigger_v3_if.slave thr_if,
    input  logic [HOLDBITS-1:0]              holdoff_i,
    input  logic [NBEAMS-1:0]                mask_i,
    output logic [NBEAMS*ENVBITS-1:0]        envelope_o,
    output logic [2*NBEAMS-1:0]              trigger_o
);

    localparam int unsigned K     = boxcar_k(BOXLEN, NSAMP);
    localparam int unsigned NCH   = 2 * NBEAMS;
    localparam int unsigned BLKW  = SQBITS + $clog2(NSAMP);
    localparam int unsigned SUMW  = BLKW + $clog2(K);
    localparam int unsigned FILLW = $clog2(K + 3);
    localparam logic [FILLW-1:0] FILL_DONE = FILLW'(K + 2);

    if (K == 0) begin : g_bad_boxlen
        $error("BOXLEN must equal NSAMP*K with K in {1,2,4,8}");
    end
    if (SUMW > 32) begin : g_bad_width
        $error("boxcar sum wider than 32 bits");
    end

    logic [BLKW-1:0]    w_blk    [NBEAMS];
    logic [BLKW-1:0]    r_blk    [NBEAMS];
    logic [BLKW-1:0]    r_hist   [NBEAMS][K];
    logic [SUMW-1:0]    w_sum    [NBEAMS];
    logic [31:0]        w_wide   [NBEAMS];
    logic [ENVBITS-1:0] w_sat    [NBEAMS];
    logic [ENVBITS-1:0] r_env    [NBEAMS];
    logic [FILLW-1:0]   r_fill;
    logic [ENVBITS-1:0] r_shadow [NCH];
    logic [ENVBITS-1:0] r_active [NCH];
    logic [NCH-1:0]     w_hit;
    logic [NCH-1:0]     w_trig;

    // Stage 1: block sum of NSAMP squares per beam.
    always_comb begin
        for (int unsigned b = 0; b < NBEAMS; b++) begin
            w_blk[b] = '0;
            for (int unsigned s = 0; s < NSAMP; s++) begin
                w_blk[b] = w_blk[b] + BLKW'(square_i[(b*NSAMP+s)*SQBITS +: SQBITS]);
            end
        end
    end

    // Stage 2: history of the last K block sums.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned b = 0; b < NBEAMS; b++) begin
                r_blk[b] <= '0;
                for (int unsigned k = 0; k < K; k++) begin
                    r_hist[b][k] <= '0;
                end
            end
        end else begin
            for (int unsigned b = 0; b < NBEAMS; b++) begin
                r_blk[b]     <= w_blk[b];
                r_hist[b][0] <= r_blk[b];
                for (int unsigned k = 1; k < K; k++) begin
                    r_hist[b][k] <= r_hist[b][k-1];
                end
            end
        end
    end

    // Envelope sum and clamp to 18 bits unsigned.
    always_comb begin
        for (int unsigned b = 0; b < NBEAMS; b++) begin
            w_sum[b] = '0;
            for (int unsigned k = 0; k < K; k++) begin
                w_sum[b] = w_sum[b] + SUMW'(r_hist[b][k]);
            end
            w_wide[b] = 32'(w_sum[b]);
            w_sat[b]  = (w_wide[b] > 32'(THRESH_RESET)) ? THRESH_RESET
                                                        : w_wide[b][ENVBITS-1:0];
        end
    end

    // Stage 3: registered envelope.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned b = 0; b < NBEAMS; b++) begin
                r_env[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NBEAMS; b++) begin
                r_env[b] <= w_sat[b];
            end
        end
    end

    always_comb begin
        envelope_o = '0;
        for (int unsigned b = 0; b < NBEAMS; b++) begin
            envelope_o[b*ENVBITS +: ENVBITS] = r_env[b];
        end
    end

    // Reaches K+2 on the first clock where r_env holds a fully populated window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fill <= '0;
        end else if (r_fill != FILL_DONE) begin
            r_fill <= r_fill + FILLW'(1);
        end
    end

    // Double-buffered thresholds. Update copies the pre-write shadow value
    // when both strobes coincide, since both use non-blocking updates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                r_shadow[c] <= THRESH_RESET;
                r_active[c] <= THRESH_RESET;
            end
        end else begin
            if (thr_if.thresh_update) begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    r_active[c] <= r_shadow[c];
                end
            end
            if (thr_if.thresh_wr && (32'(thr_if.thresh_addr) < NCH)) begin
                r_shadow[thr_if.thresh_addr] <= thr_if.thresh_dat;
            end
        end
    end

    always_comb begin
        w_hit = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_hit[c] = (r_fill == FILL_DONE) && (r_env[c/2] > r_active[c]);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        lowamp_trig_holdoff #(
            .HOLDBITS(HOLDBITS)
        ) u_holdoff (
            .i_clk     (clk_i),
            .i_rst     (rst_i),
            .i_hit     (w_hit[c]),
            .i_mask    (mask_i[c/2]),
            .i_holdoff (holdoff_i),
            .o_trig    (w_trig[c])
        );
    end

    assign trigger_o = w_trig;

endmodule

// File: tb/tb_pueo_lowamp_envelope_trigger_v3.sv
module tb_pueo_lowamp_envelope_trigger_v3;
    import pueo_lowamp_pkg::*;

    localparam int unsigned NB = 2;
    localparam int unsigned NS = 4;
    localparam int unsigned SQ = 14;
    localparam int unsigned HB = 8;
    localparam int unsigned EW = NB * 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, rst32;
    logic [NB*NS*SQ-1:0] square, square32;
    logic [HB-1:0]      holdoff, holdoff32;
    logic [NB-1:0]      mask, mask32;
    logic [EW-1:0]      env, env32;
    logic [2*NB-1:0]    trig, trig32;

    pueo_lowamp_envelope_trigger_v3_if #(.NBEAMS(NB)) thr_if ();
    pueo_lowamp_envelope_trigger_v3_if #(.NBEAMS(NB)) thr32_if ();

    pueo_lowamp_envelope_trigger_v3 #(
        .NBEAMS(NB), .NSAMP(NS), .SQBITS(SQ), .BOXLEN(8), .HOLDBITS(HB)
    ) dut (
        .clk_i(clk), .rst_i(rst), .square_i(square), .thr_if(thr_if),
        .holdoff_i(holdoff), .mask_i(mask), .envelope_o(env), .trigger_o(trig)
    );

    pueo_lowamp_envelope_trigger_v3 #(
        .NBEAMS(NB), .NSAMP(NS), .SQBITS(SQ), .BOXLEN(32), .HOLDBITS(HB)
    ) dut32 (
        .clk_i(clk), .rst_i(rst32), .square_i(square32), .thr_if(thr32_if),
        .holdoff_i(holdoff32), .mask_i(mask32), .envelope_o(env32), .trigger_o(trig32)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    bit          sb_en = 1'b0;
    int unsigned sq   [NB][NS];
    int unsigned hist [NB][2];
    logic [EW-1:0] exp_q[$];

    task automatic set_sq(input int unsigned v);
        for (int unsigned b = 0; b < NB; b++)
            for (int unsigned s = 0; s < NS; s++)
                sq[b][s] = v;
    endtask

    // Advance one clock; scoreboard pushes the expected envelope of the
    // sample being presented and pops the one due three clocks earlier.
    task automatic step();
        logic [EW-1:0] e;
        logic [EW-1:0] want;
        int unsigned   tot;
        e = '0;
        for (int unsigned b = 0; b < NB; b++)
            for (int unsigned s = 0; s < NS; s++)
                square[(b*NS+s)*SQ +: SQ] = SQ'(sq[b][s]);
        if (sb_en) begin
            for (int unsigned b = 0; b < NB; b++) begin
                hist[b][1] = hist[b][0];
                hist[b][0] = 0;
                for (int unsigned s = 0; s < NS; s++) hist[b][0] += sq[b][s];
                tot = hist[b][0] + hist[b][1];
                e[b*18 +: 18] = (tot > 262143) ? 18'h3FFFF : 18'(tot);
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (sb_en) begin
            want = exp_q.pop_front();
            n_cmp++;
            if (env !== want) begin
                n_bad++;
                $display("FAIL envelope cyc=%0d got=%h exp=%h", cyc, env, want);
            end
        end
    endtask

    task automatic apply_reset(input int unsigned ncyc);
        sb_en = 1'b0;
        rst   = 1'b1;
        repeat (ncyc) step();
        rst = 1'b0;
        cyc = 0;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        for (int unsigned b = 0; b < NB; b++) begin
            hist[b][0] = 0;
            hist[b][1] = 0;
        end
        sb_en = 1'b1;
    endtask

    task automatic wait_pulse(input int unsigned ch, input int unsigned maxc,
                              output bit found, output int unsigned at);
        found = 1'b0;
        at    = 0;
        for (int unsigned i = 0; i < maxc && !found; i++) begin
            step();
            if (trig[ch]) begin
                found = 1'b1;
                at    = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst32 = 1'b1;
        set_sq(100);
        for (int unsigned b = 0; b < NB; b++)
            for (int unsigned s = 0; s < NS; s++)
                square32[(b*NS+s)*SQ +: SQ] = SQ'(16383);
        square = '0;
        holdoff = '0; holdoff32 = '0; mask = '0; mask32 = '0;
        thr_if.thresh_dat = '0; thr_if.thresh_addr = '0;
        thr_if.thresh_wr = 1'b0; thr_if.thresh_update = 1'b0;
        thr32_if.thresh_dat = '0; thr32_if.thresh_addr = '0;
        thr32_if.thresh_wr = 1'b0; thr32_if.thresh_update = 1'b0;
        #1;
        n_cmp++; if (env !== '0)    begin n_bad++; $display("FAIL reset_env got=%h exp=0", env); end
        n_cmp++; if (trig !== '0)   begin n_bad++; $display("FAIL reset_trig got=%b exp=0", trig); end
        n_cmp++; if (env32 !== '0)  begin n_bad++; $display("FAIL reset_env32 got=%h exp=0", env32); end
        n_cmp++; if (trig32 !== '0) begin n_bad++; $display("FAIL reset_trig32 got=%b exp=0", trig32); end
        step(); step();
        rst32 = 1'b0;
    endtask

    task automatic test_fill_latency();
        logic [2*NB-1:0] early;
        set_sq(100);
        holdoff = '0;
        apply_reset(2);
        thr_if.thresh_wr = 1'b1; thr_if.thresh_addr = 2'd0; thr_if.thresh_dat = '0;
        step();
        early = trig;
        thr_if.thresh_wr = 1'b0; thr_if.thresh_update = 1'b1;
        step();
        early |= trig;
        thr_if.thresh_update = 1'b0;
        step();
        early |= trig;
        step();
        early |= trig;
        n_cmp++; if (early !== '0) begin n_bad++; $display("FAIL fill_suppress got=%b exp=0000", early); end
        n_cmp++; if (env !== {18'd800, 18'd800}) begin n_bad++; $display("FAIL env800 got=%h exp=%h", env, {18'd800, 18'd800}); end
        step();
        n_cmp++; if (trig !== 4'b0001) begin n_bad++; $display("FAIL first_trig cyc=%0d got=%b exp=0001", cyc, trig); end
    endtask

    task automatic test_envelope_patterns();
        for (int unsigned i = 0; i < 10; i++) begin
            for (int unsigned b = 0; b < NB; b++)
                for (int unsigned s = 0; s < NS; s++)
                    sq[b][s] = $urandom_range(0, 16383);
            step();
        end
        set_sq(16383); step(); step();
        set_sq(0);     step();
        set_sq(100);
        repeat (4) step();
    endtask

    task automatic test_threshold_edge();
        int unsigned cnt0, cnt1;
        bit          any1;
        thr_if.thresh_wr = 1'b1; thr_if.thresh_addr = 2'd0; thr_if.thresh_dat = 18'd799;
        step();
        thr_if.thresh_addr = 2'd1; thr_if.thresh_dat = 18'd800;
        step();
        thr_if.thresh_wr = 1'b0; thr_if.thresh_update = 1'b1;
        step();
        thr_if.thresh_update = 1'b0;
        repeat (2) step();
        cnt0 = 0; any1 = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            step();
            cnt0 += trig[0];
            any1 |= trig[1];
        end
        n_cmp++; if (cnt0 != 3) begin n_bad++; $display("FAIL thr799_pulses got=%0d exp=3", cnt0); end
        n_cmp++; if (any1 !== 1'b0) begin n_bad++; $display("FAIL thr800_nohit got=%b exp=0", any1); end
        thr_if.thresh_wr = 1'b1; thr_if.thresh_addr = 2'd1; thr_if.thresh_dat = 18'd799;
        step();
        thr_if.thresh_wr = 1'b0; thr_if.thresh_update = 1'b1;
        step();
        thr_if.thresh_update = 1'b0;
        repeat (2) step();
        cnt1 = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            step();
            cnt1 += trig[1];
        end
        n_cmp++; if (cnt1 != 3) begin n_bad++; $display("FAIL thr1_799_pulses got=%0d exp=3", cnt1); end
    endtask

    task automatic test_shadow_order();
        bit          any2;
        int unsigned cnt2;
        thr_if.thresh_wr = 1'b1; thr_if.thresh_addr = 2'd2; thr_if.thresh_dat = 18'h100;
        thr_if.thresh_update = 1'b1;
        step();
        thr_if.thresh_wr = 1'b0; thr_if.thresh_update = 1'b0;
        any2 = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            step();
            any2 |= trig[2];
        end
        n_cmp++; if (any2 !== 1'b0) begin n_bad++; $display("FAIL wr_upd_same got=%b exp=0", any2); end
        thr_if.thresh_update = 1'b1;
        step();
        thr_if.thresh_update = 1'b0;
        step();
        cnt2 = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            step();
            cnt2 += trig[2];
        end
        n_cmp++; if (cnt2 != 3) begin n_bad++; $display("FAIL late_update_pulses got=%0d exp=3", cnt2); end
    endtask

    task automatic test_holdoff();
        bit          fa, fb, fc, fd, fe, ff;
        int unsigned a, b, c, d, e, f;
        holdoff = 8'd5;
        wait_pulse(0, 20, fa, a);
        wait_pulse(0, 20, fb, b);
        n_cmp++; if (!fa || !fb || (b - a) != 7) begin n_bad++; $display("FAIL holdoff5_gap got=%0d exp=7 found=%b%b", b - a, fa, fb); end
        step(); step();
        holdoff = 8'd20;
        wait_pulse(0, 20, fc, c);
        n_cmp++; if (!fc || (c - b) != 7) begin n_bad++; $display("FAIL midhold_change got=%0d exp=7 found=%b", c - b, fc); end
        wait_pulse(0, 40, fd, d);
        n_cmp++; if (!fd || (d - c) != 22) begin n_bad++; $display("FAIL holdoff20_gap got=%0d exp=22 found=%b", d - c, fd); end
        holdoff = 8'd0;
        wait_pulse(0, 20, fe, e);
        wait_pulse(0, 20, ff, f);
        n_cmp++; if (!fe || !ff || (f - e) != 2) begin n_bad++; $display("FAIL holdoff0_gap got=%0d exp=2 found=%b%b", f - e, fe, ff); end
    endtask

    task automatic test_saturation();
        int unsigned cnt;
        bit          other;
        thr32_if.thresh_wr = 1'b1; thr32_if.thresh_addr = 2'd0; thr32_if.thresh_dat = 18'h3FFFE;
        step();
        thr32_if.thresh_addr = 2'd1; thr32_if.thresh_dat = 18'h3FFFF;
        step();
        thr32_if.thresh_wr = 1'b0; thr32_if.thresh_update = 1'b1;
        step();
        thr32_if.thresh_update = 1'b0;
        repeat (2) step();
        n_cmp++; if (env32 !== {18'h3FFFF, 18'h3FFFF}) begin n_bad++; $display("FAIL sat_env got=%h exp=%h", env32, {18'h3FFFF, 18'h3FFFF}); end
        cnt = 0; other = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            step();
            cnt += trig32[0];
            other |= |trig32[3:1];
        end
        n_cmp++; if (cnt != 3) begin n_bad++; $display("FAIL sat_3fffe_pulses got=%0d exp=3", cnt); end
        n_cmp++; if (other !== 1'b0) begin n_bad++; $display("FAIL sat_3ffff_nohit got=%b exp=0", other); end
    endtask

    task automatic test_mask();
        bit              f;
        int unsigned     t;
        logic [2*NB-1:0] seen;
        holdoff = 8'd5;
        wait_pulse(2, 20, f, t);
        n_cmp++; if (!f) begin n_bad++; $display("FAIL mask_prepulse got=none exp=pulse"); end
        mask = 2'b10;
        #1;
        n_cmp++; if (trig[3:2] !== 2'b00) begin n_bad++; $display("FAIL mask_immediate got=%b exp=00", trig[3:2]); end
        step();
        seen = trig;
        step();
        seen |= trig;
        n_cmp++; if (seen[3:2] !== 2'b00) begin n_bad++; $display("FAIL mask_hold got=%b exp=00", seen[3:2]); end
        n_cmp++; if (env[35:18] !== 18'd800) begin n_bad++; $display("FAIL mask_env got=%0d exp=800", env[35:18]); end
        mask = 2'b00;
        step();
        n_cmp++; if (trig[2] !== 1'b1) begin n_bad++; $display("FAIL mask_rearm got=%b exp=1", trig[2]); end
    endtask

    task automatic test_reset_mid();
        bit              f;
        int unsigned     t;
        logic [2*NB-1:0] seen;
        wait_pulse(0, 20, f, t);
        step(); step();
        #3;
        sb_en = 1'b0;
        rst   = 1'b1;
        #1;
        n_cmp++; if (trig !== '0) begin n_bad++; $display("FAIL async_rst_trig got=%b exp=0", trig); end
        n_cmp++; if (env !== '0)  begin n_bad++; $display("FAIL async_rst_env got=%h exp=0", env); end
        set_sq(16383);
        apply_reset(2);
        seen = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            step();
            seen |= trig;
        end
        n_cmp++; if (seen !== '0) begin n_bad++; $display("FAIL thr_reset_nohit got=%b exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_fill_latency();
        test_envelope_patterns();
        test_threshold_edge();
        test_shadow_order();
        test_holdoff();
        test_saturation();
        test_mask();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
